// File: rtl/buf_ram_1p_param_pkg.sv
// Package for buf_ram_1p_param: clear-FSM state type built from the shared
// encodings, plus the default pixel width as a typed constant.
`include "enc_defines.sv"

package buf_ram_1p_param_pkg;

  localparam int BUF_PIXEL_WIDTH = `PIXEL_WIDTH;

  typedef enum logic {
    ST_IDLE  = `ENC_ST_IDLE,
    ST_CLEAR = `ENC_ST_CLEAR
  } clr_state_e;

endpackage

// File: rtl/buf_ram_1p_param_core.sv
// Storage core for buf_ram_1p_param: one array per lane so each lane is
// written independently under its mask bit; read data is registered and
// only reloads on a read, so it holds the last read word otherwise.
// Ports:
//   clk_i    clock (rising edge)       rst_i   async active-high reset (read reg only)
//   we_i     write strobe              re_i    read strobe
//   wmask_i  per-lane write enable     addr_i  word address
//   wdata_i  write word                rdata_o registered read word
module buf_ram_1p_param_core #(
  parameter int ADDR_WIDTH = 6,
  parameter int LANE_NUM   = 8,
  parameter int LANE_WIDTH = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           we_i,
  input  logic                           re_i,
  input  logic [LANE_NUM-1:0]            wmask_i,
  input  logic [ADDR_WIDTH-1:0]          addr_i,
  input  logic [LANE_NUM*LANE_WIDTH-1:0] wdata_i,
  output logic [LANE_NUM*LANE_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int DW    = LANE_NUM * LANE_WIDTH;

  logic [DW-1:0] rd_word_s;
  logic [DW-1:0] rdata_q;

  for (genvar g = 0; g < LANE_NUM; g++) begin : g_lane
    // Storage is deliberately not reset; contents survive rst.
    logic [LANE_WIDTH-1:0] lane_mem_q [DEPTH];

    // Masked lane write.
    always_ff @(posedge clk_i) begin
      if (we_i && wmask_i[g]) begin
        lane_mem_q[addr_i] <= wdata_i[g*LANE_WIDTH +: LANE_WIDTH];
      end
    end

    assign rd_word_s[g*LANE_WIDTH +: LANE_WIDTH] = lane_mem_q[addr_i];
  end

  // Registered read port; holds its value between reads.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= rd_word_s;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/enc_defines.sv
// Shared encoder definitions: pixel width and clear-FSM state encodings.
// Included (guarded) by every file that needs them.
`ifndef ENC_DEFINES_SV
`define ENC_DEFINES_SV

`define PIXEL_WIDTH  8
`define ENC_ST_IDLE  1'b0
`define ENC_ST_CLEAR 1'b1

`endif

// File: rtl/buf_ram_1p_param.sv
// Single-port lane-masked buffer RAM with optional output register and an
// optional post-reset clear sweep (enabled by macro BUF_RAM_1P_CLEAR_EN).
// With the sweep enabled, every reset zeroes all DEPTH words, one per cycle,
// while busy_o is high and user accesses are ignored.
// Ports:
//   clk, rst (async, active high), ce, we, wmask[LANE_NUM], addr[ADDR_WIDTH],
//   data_i[DW] in; data_o[DW], valid_o, busy_o out.
// Read latency: 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1).
`include "enc_defines.sv"

module buf_ram_1p_param
  import buf_ram_1p_param_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int LANE_NUM   = 8,
  parameter int LANE_WIDTH = `PIXEL_WIDTH,
  parameter int OUT_REG    = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ce,
  input  logic                           we,
  input  logic [LANE_NUM-1:0]            wmask,
  input  logic [ADDR_WIDTH-1:0]          addr,
  input  logic [LANE_NUM*LANE_WIDTH-1:0] data_i,
  output logic [LANE_NUM*LANE_WIDTH-1:0] data_o,
  output logic                           valid_o,
  output logic                           busy_o
);

  localparam int DW = LANE_NUM * LANE_WIDTH;

  logic                  busy_s;
  logic [ADDR_WIDTH-1:0] clr_addr_s;
  logic                  rd_s;
  logic                  wr_s;
  logic                  core_we_s;
  logic [LANE_NUM-1:0]   core_wmask_s;
  logic [ADDR_WIDTH-1:0] core_addr_s;
  logic [DW-1:0]         core_wdata_s;
  logic [DW-1:0]         core_rdata_s;
  logic                  rd_vld_q;

`ifdef BUF_RAM_1P_CLEAR_EN
  clr_state_e            state_q;
  logic [ADDR_WIDTH-1:0] clr_addr_q;
  logic                  busy_q;

  // Clear sweep FSM: reset lands in CLEAR at address 0; the counter wraps
  // naturally back to 0 as the last word is cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      busy_q     <= 1'b1;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          clr_addr_q <= clr_addr_q + ADDR_WIDTH'(1);
          if (clr_addr_q == {ADDR_WIDTH{1'b1}}) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_IDLE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q    <= ST_CLEAR;
          clr_addr_q <= '0;
          busy_q     <= 1'b1;
        end
      endcase
    end
  end

  assign busy_s     = busy_q;
  assign clr_addr_s = clr_addr_q;
`else
  assign busy_s     = 1'b0;
  assign clr_addr_s = '0;
`endif

  assign busy_o = busy_s;

  // Request gating: the sweep owns the port while busy.
  always_comb begin
    rd_s = ce & ~we & ~busy_s;
    wr_s = ce & we & ~busy_s;
    if (busy_s) begin
      core_we_s    = 1'b1;
      core_wmask_s = '1;
      core_addr_s  = clr_addr_s;
      core_wdata_s = '0;
    end else begin
      core_we_s    = wr_s;
      core_wmask_s = wmask;
      core_addr_s  = addr;
      core_wdata_s = data_i;
    end
  end

  buf_ram_1p_param_core #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LANE_NUM   (LANE_NUM),
    .LANE_WIDTH (LANE_WIDTH)
  ) u_core (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (core_we_s),
    .re_i    (rd_s),
    .wmask_i (core_wmask_s),
    .addr_i  (core_addr_s),
    .wdata_i (core_wdata_s),
    .rdata_o (core_rdata_s)
  );

  // Valid tracks the read strobe alongside the core's read register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld_q <= 1'b0;
    end else begin
      rd_vld_q <= rd_s;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DW-1:0] out_data_q;
    logic          out_vld_q;

    // Extra output stage; captures only fresh read data so data_o holds.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out_data_q <= '0;
        out_vld_q  <= 1'b0;
      end else begin
        out_vld_q <= rd_vld_q;
        if (rd_vld_q) begin
          out_data_q <= core_rdata_s;
        end
      end
    end

    assign data_o  = out_data_q;
    assign valid_o = out_vld_q;
  end else begin : g_no_out_reg
    assign data_o  = core_rdata_s;
    assign valid_o = rd_vld_q;
  end

endmodule

// File: tb/tb_buf_ram_1p_param.sv
// Randomized self-checking bench for buf_ram_1p_param. Two instances share
// stimulus: one with OUT_REG=0 and one with OUT_REG=1. A word-array model
// with a queue of expected read results (each tagged with its due cycle)
// predicts valid_o/data_o every cycle; busy_o is predicted from a count of
// remaining sweep cycles.
module tb_buf_ram_1p_param;

  localparam int AW    = 6;
  localparam int LN    = 8;
  localparam int LW    = 8;
  localparam int DW    = LN * LW;
  localparam int DEPTH = 1 << AW;
`ifdef BUF_RAM_1P_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ce = 1'b0;
  logic          we = 1'b0;
  logic [LN-1:0] wmask = '0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] data_i = '0;
  logic [DW-1:0] d0, d1;
  logic          v0, v1, b0, b1;

  always #5 clk = ~clk;

  buf_ram_1p_param #(.ADDR_WIDTH(AW), .LANE_NUM(LN), .LANE_WIDTH(LW), .OUT_REG(0)) u_dut0 (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .wmask(wmask), .addr(addr),
    .data_i(data_i), .data_o(d0), .valid_o(v0), .busy_o(b0)
  );

  buf_ram_1p_param #(.ADDR_WIDTH(AW), .LANE_NUM(LN), .LANE_WIDTH(LW), .OUT_REG(1)) u_dut1 (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .wmask(wmask), .addr(addr),
    .data_i(data_i), .data_o(d1), .valid_o(v1), .busy_o(b1)
  );

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rd_t;

  logic [DW-1:0] mem_m [DEPTH];
  rd_t           q0[$];
  rd_t           q1[$];
  logic [DW-1:0] last0 = '0;
  logic [DW-1:0] last1 = '0;
  int            cyc = 0;
  int            sweep_left = 0;
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    logic [63:0] exp_busy;
    exp_busy = (sweep_left > 0) ? 64'd1 : 64'd0;
    check("busy0", 64'(b0), exp_busy);
    check("busy1", 64'(b1), exp_busy);
    if (q0.size() > 0 && q0[0].due == cyc) begin
      check("valid0", 64'(v0), 64'd1);
      check("data0", d0, q0[0].data);
      last0 = q0[0].data;
      void'(q0.pop_front());
    end else begin
      check("valid0_idle", 64'(v0), 64'd0);
      check("data0_hold", d0, last0);
    end
    if (q1.size() > 0 && q1[0].due == cyc) begin
      check("valid1", 64'(v1), 64'd1);
      check("data1", d1, q1[0].data);
      last1 = q1[0].data;
      void'(q1.pop_front());
    end else begin
      check("valid1_idle", 64'(v1), 64'd0);
      check("data1_hold", d1, last1);
    end
  endtask

  // One clock cycle: drive, update the model, clock, check.
  task automatic step(input logic c, input logic w, input logic [LN-1:0] m,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit acc;
    ce = c; we = w; wmask = m; addr = a; data_i = d;
    acc = c && (sweep_left == 0);
    if (acc && !w) begin
      q0.push_back('{due: cyc + 1, data: mem_m[a]});
      q1.push_back('{due: cyc + 2, data: mem_m[a]});
    end
    if (acc && w) begin
      for (int i = 0; i < LN; i++) begin
        if (m[i]) mem_m[a][i*LW +: LW] = d[i*LW +: LW];
      end
    end
    @(posedge clk);
    cyc++;
    if (sweep_left > 0) sweep_left--;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic do_reset(input int hold);
    ce = 1'b0; we = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_valid0", 64'(v0), 64'd0);
    check("rst_valid1", 64'(v1), 64'd0);
    check("rst_data0", d0, 64'd0);
    check("rst_data1", d1, 64'd0);
    check("rst_busy0", 64'(b0), CLR_EN ? 64'd1 : 64'd0);
    q0.delete();
    q1.delete();
    last0 = '0;
    last1 = '0;
    if (CLR_EN) begin
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    end
    repeat (hold) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    rst = 1'b0;
    sweep_left = CLR_EN ? DEPTH : 0;
  endtask

  // Random access issued only while the model expects the sweep to be busy.
  task automatic busy_poke();
    if (sweep_left > 0) begin
      step(1'b1, 1'($urandom_range(0, 1)), LN'($urandom), AW'($urandom), {$urandom, $urandom});
    end else begin
      idle();
    end
  endtask

  initial begin
    int n_busy;
    logic [DW-1:0] rd;
    @(negedge clk);
    do_reset(2);

    // Reset pulsed 30 cycles into the sweep; accesses during busy are ignored.
    repeat (30) busy_poke();
    do_reset(1);
    n_busy = 0;
    repeat (DEPTH + 6) begin
      busy_poke();
      if (b0 === 1'b1) n_busy++;
    end
    check("busy_cycles", 64'(n_busy), CLR_EN ? 64'd64 : 64'd0);

`ifdef BUF_RAM_1P_CLEAR_EN
    // Swept words read back as zero.
    step(1'b1, 1'b0, '0, 6'd0, '0);
    step(1'b1, 1'b0, '0, 6'd63, '0);
    idle();
    idle();
`endif

    // Masked read-modify on address 5.
    step(1'b1, 1'b1, 8'hFF, 6'd5, 64'h0807060504030201);
    step(1'b1, 1'b1, 8'h0F, 6'd5, {8{8'hAA}});
    step(1'b1, 1'b0, '0, 6'd5, '0);
    check("rmw_addr5_r0", d0, 64'h08070605AAAAAAAA);
    idle();
    check("rmw_addr5_r1", d1, 64'h08070605AAAAAAAA);

    // Top address write then read.
    rd = {$urandom, $urandom};
    step(1'b1, 1'b1, 8'hFF, 6'd63, rd);
    step(1'b1, 1'b0, '0, 6'd63, '0);
    check("addr63_r0", d0, rd);
    idle();
    idle();

    // Fill every word so later random reads are always defined.
    for (int a = 0; a < DEPTH; a++) step(1'b1, 1'b1, 8'hFF, AW'(a), {$urandom, $urandom});

    // Back-to-back reads of 1, 2, 3.
    step(1'b1, 1'b0, '0, 6'd1, '0);
    step(1'b1, 1'b0, '0, 6'd2, '0);
    step(1'b1, 1'b0, '0, 6'd3, '0);
    idle();
    idle();

    // Random traffic.
    repeat (1500) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), LN'($urandom),
           AW'($urandom), {$urandom, $urandom});
    end

    // Reset with a read in flight; storage survives unless swept.
    step(1'b1, 1'b0, '0, AW'($urandom), '0);
    do_reset(2);
    repeat (DEPTH + 4) idle();
    repeat (8) step(1'b1, 1'b0, '0, AW'($urandom), '0);
    idle();
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
